// File: rtl/oldland_bus_pkg.sv
// rtl/oldland_bus_pkg.sv - shared types and constants for the oldland bus arbiter
//
// Purpose: state encoding, master identifiers and the default bus timeout
// used by oldland_bus_arbiter and oldland_bus_timeout.
// Ports: none (package).

package oldland_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2
    } bus_state_t;

    // Identity of the master that received the most recent grant.
    typedef enum logic {
        MASTER_I = 1'b0,
        MASTER_D = 1'b1
    } master_id_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    // Byte enables used for every instruction fetch (full word).
    localparam logic [3:0] FETCH_BYTESEL = 4'b1111;

endpackage

// File: rtl/oldland_bus_timeout.sv
// rtl/oldland_bus_timeout.sv - load/enable cycle counter with expiry flag
//
// Purpose: counts granted bus cycles that saw no slave response so the
// arbiter can abandon a transaction to a dead slave.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   load      - clear the count (held while the bus is idle)
//   enable    - count this cycle
//   expired   - count has reached LIMIT-1, i.e. this is the LIMIT-th
//               unanswered granted cycle

module oldland_bus_timeout #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    assign expired = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/oldland_bus_arbiter.sv
// rtl/oldland_bus_arbiter.sv - round-robin arbiter for fetch and data masters
//
// Purpose: shares one external memory bus between the instruction fetch
// port (i_*) and the memory-stage data port (d_*). Ties are resolved in
// favour of the master not granted last. The winning request is latched into
// registered m_* outputs for the whole transaction; the slave's ack/error
// and read data are routed combinationally back to the granted master only.
// Optional build macro: OLDLAND_BUS_TIMEOUT_EN adds a TIMEOUT_CYCLES
// watchdog that aborts a grant with an error pulse.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   i_addr/i_access          - fetch request; i_data/i_ack/i_error response
//   d_addr/d_bytesel/d_wr_en/d_wr_val/d_access - data request
//   d_data/d_ack/d_error     - data response
//   m_addr/m_bytesel/m_wr_en/m_wr_val/m_access - registered bus request
//   m_data/m_ack/m_error     - bus response

module oldland_bus_arbiter
    import oldland_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] i_addr,
    input  logic        i_access,
    output logic [31:0] i_data,
    output logic        i_ack,
    output logic        i_error,

    input  logic [31:0] d_addr,
    input  logic [3:0]  d_bytesel,
    input  logic        d_wr_en,
    input  logic [31:0] d_wr_val,
    input  logic        d_access,
    output logic [31:0] d_data,
    output logic        d_ack,
    output logic        d_error,

    output logic [31:0] m_addr,
    output logic [3:0]  m_bytesel,
    output logic        m_wr_en,
    output logic [31:0] m_wr_val,
    output logic        m_access,
    input  logic [31:0] m_data,
    input  logic        m_ack,
    input  logic        m_error
);

    bus_state_t state;
    master_id_t last;

    logic grant_d;
    logic grant_i;
    logic granted;
    logic timeout_hit;
    logic finish;

    // Data wins when it is the only requester or when fetch had the last grant.
    assign grant_d = d_access && (!i_access || (last == MASTER_I));
    assign grant_i = i_access && !grant_d;
    assign granted = (state == ST_GRANT_I) || (state == ST_GRANT_D);

`ifdef OLDLAND_BUS_TIMEOUT_EN
    logic expired;

    // Held in load while idle so the count is zero on the first granted cycle.
    oldland_bus_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (!granted),
        .enable (granted && !m_ack && !m_error),
        .expired(expired)
    );

    // A real slave response in the expiry cycle takes precedence.
    assign timeout_hit = granted && expired && !m_ack && !m_error;
`else
    logic cfg_unused;
    assign cfg_unused  = |TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    assign finish = m_ack || m_error || timeout_hit;

    // Response routing: error dominates ack; the ungranted side sees zeros.
    assign i_ack   = (state == ST_GRANT_I) && m_ack && !m_error && !timeout_hit;
    assign i_error = (state == ST_GRANT_I) && (m_error || timeout_hit);
    assign d_ack   = (state == ST_GRANT_D) && m_ack && !m_error && !timeout_hit;
    assign d_error = (state == ST_GRANT_D) && (m_error || timeout_hit);

    // Read data is simply forwarded; only meaningful alongside the ack.
    assign i_data = m_data;
    assign d_data = m_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            last      <= MASTER_I;
            m_addr    <= '0;
            m_bytesel <= '0;
            m_wr_en   <= 1'b0;
            m_wr_val  <= '0;
            m_access  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        state     <= ST_GRANT_D;
                        last      <= MASTER_D;
                        m_addr    <= d_addr;
                        m_bytesel <= d_bytesel;
                        m_wr_en   <= d_wr_en;
                        m_wr_val  <= d_wr_val;
                        m_access  <= 1'b1;
                    end else if (grant_i) begin
                        state     <= ST_GRANT_I;
                        last      <= MASTER_I;
                        m_addr    <= i_addr;
                        m_bytesel <= FETCH_BYTESEL;
                        m_wr_en   <= 1'b0;
                        m_wr_val  <= '0;
                        m_access  <= 1'b1;
                    end
                end
                ST_GRANT_I, ST_GRANT_D: begin
                    // Request fields stay frozen; only completion releases the bus,
                    // regardless of whether the master still holds its access line.
                    if (finish) begin
                        state    <= ST_IDLE;
                        m_access <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    m_access <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oldland_bus_arbiter.sv
// tb/tb_oldland_bus_arbiter.sv - self-checking bench for oldland_bus_arbiter

module tb_oldland_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_addr = '0;
    logic        i_access = 1'b0;
    logic [31:0] i_data;
    logic        i_ack, i_error;
    logic [31:0] d_addr = '0;
    logic [3:0]  d_bytesel = '0;
    logic        d_wr_en = 1'b0;
    logic [31:0] d_wr_val = '0;
    logic        d_access = 1'b0;
    logic [31:0] d_data;
    logic        d_ack, d_error;
    logic [31:0] m_addr;
    logic [3:0]  m_bytesel;
    logic        m_wr_en;
    logic [31:0] m_wr_val;
    logic        m_access;
    logic [31:0] m_data = '0;
    logic        m_ack = 1'b0;
    logic        m_error = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    oldland_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_access(i_access), .i_data(i_data),
        .i_ack(i_ack), .i_error(i_error),
        .d_addr(d_addr), .d_bytesel(d_bytesel), .d_wr_en(d_wr_en),
        .d_wr_val(d_wr_val), .d_access(d_access), .d_data(d_data),
        .d_ack(d_ack), .d_error(d_error),
        .m_addr(m_addr), .m_bytesel(m_bytesel), .m_wr_en(m_wr_en),
        .m_wr_val(m_wr_val), .m_access(m_access), .m_data(m_data),
        .m_ack(m_ack), .m_error(m_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Reference model state for the random phase (0 none, 1 fetch, 2 data).
    int          owner;
    int          last_g;
    int          wait_cnt;
    bit          pend_i, pend_d;
    bit          ack_now, err_now;
    logic [31:0] ri_addr, rd_addr, rd_wr_val;
    logic [3:0]  rd_bytesel;
    logic        rd_wr_en;
    logic [31:0] e_addr, e_wr_val;
    logic [3:0]  e_bytesel;
    logic        e_wr_en;
    int          r;

    initial begin
        // ---- reset state ----
        tick();
        sample();
        chk("rst_m_access", m_access, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wr_en", m_wr_en, 0);
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_d_error", d_error, 0);
        tick();
        rst = 1'b0;

        // ---- single data store, slave acks 2 cycles after m_access ----
        tick();
        d_access = 1; d_addr = 32'h1000; d_wr_en = 1; d_wr_val = 32'hdeadbeef; d_bytesel = 4'hf;
        sample();
        chk("st_req_cycle_m_access", m_access, 0);
        tick();
        sample();
        chk("st_m_access", m_access, 1);
        chk("st_m_addr", m_addr, 32'h1000);
        chk("st_m_wr_val", m_wr_val, 32'hdeadbeef);
        chk("st_m_wr_en", m_wr_en, 1);
        chk("st_m_bytesel", m_bytesel, 4'hf);
        chk("st_d_ack_early", d_ack, 0);
        tick();
        sample();
        chk("st_wait_m_access", m_access, 1);
        chk("st_wait_d_ack", d_ack, 0);
        tick();
        m_ack = 1;
        sample();
        chk("st_d_ack", d_ack, 1);
        chk("st_i_ack", i_ack, 0);
        chk("st_d_error", d_error, 0);
        tick();
        m_ack = 0; d_access = 0;
        sample();
        chk("st_done_m_access", m_access, 0);
        chk("st_done_d_ack", d_ack, 0);

        // ---- fetch with read data ----
        tick();
        i_access = 1; i_addr = 32'h2000;
        tick();
        sample();
        chk("f_m_access", m_access, 1);
        chk("f_m_addr", m_addr, 32'h2000);
        chk("f_m_wr_en", m_wr_en, 0);
        chk("f_m_bytesel", m_bytesel, 4'hf);
        chk("f_m_wr_val", m_wr_val, 0);
        tick();
        m_data = 32'h12345678; m_ack = 1;
        sample();
        chk("f_i_ack", i_ack, 1);
        chk("f_i_data", i_data, 32'h12345678);
        chk("f_d_ack", d_ack, 0);
        chk("f_ack_m_wr_en", m_wr_en, 0);
        chk("f_ack_m_bytesel", m_bytesel, 4'hf);
        tick();
        m_ack = 0; i_access = 0;
        sample();
        chk("f_done_m_access", m_access, 0);

        // ---- tie held: D, I, D, I with 2-cycle spacing ----
        tick();
        i_access = 1; d_access = 1; i_addr = 32'h3000; d_addr = 32'h4000; d_wr_en = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            m_ack = 1;
            sample();
            chk($sformatf("tie%0d_m_access", k), m_access, 1);
            chk($sformatf("tie%0d_m_addr", k), m_addr, (k % 2 == 0) ? 32'h4000 : 32'h3000);
            chk($sformatf("tie%0d_d_ack", k), d_ack, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("tie%0d_i_ack", k), i_ack, (k % 2 == 0) ? 0 : 1);
            tick();
            m_ack = 0;
            if (k == 3) begin
                i_access = 0; d_access = 0;
            end
            sample();
            chk($sformatf("tie%0d_gap_m_access", k), m_access, 0);
        end

        // ---- ack and error together: error wins ----
        tick();
        d_access = 1; d_addr = 32'h5000; d_wr_en = 0;
        tick();
        m_ack = 1; m_error = 1;
        sample();
        chk("ae_d_error", d_error, 1);
        chk("ae_d_ack", d_ack, 0);
        chk("ae_i_error", i_error, 0);
        tick();
        m_ack = 0; m_error = 0; d_access = 0;
        sample();
        chk("ae_idle_m_access", m_access, 0);
        chk("ae_idle_d_error", d_error, 0);

        // ---- reset mid-grant, then first tie goes to data ----
        tick();
        i_access = 1; i_addr = 32'h7000;
        tick();
        sample();
        chk("rmg_granted", m_access, 1);
        #1 rst = 1; m_ack = 1;
        #1;
        chk("rmg_m_access", m_access, 0);
        chk("rmg_i_ack", i_ack, 0);
        chk("rmg_i_error", i_error, 0);
        tick();
        rst = 0; m_ack = 0; i_access = 1; d_access = 1; d_addr = 32'h6000;
        tick();
        m_ack = 1;
        sample();
        chk("rmg_tie_m_addr", m_addr, 32'h6000);
        chk("rmg_tie_d_ack", d_ack, 1);
        tick();
        m_ack = 0; i_access = 0; d_access = 0;

        // ---- watchdog ----
        tick();
        d_access = 1; d_addr = 32'h8000;
`ifdef OLDLAND_BUS_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            tick();
            sample();
            chk($sformatf("to_cycle%0d_m_access", k), m_access, 1);
            chk($sformatf("to_cycle%0d_d_error", k), d_error, (k == 4) ? 1 : 0);
        end
        tick();
        d_access = 0;
        sample();
        chk("to_after_m_access", m_access, 0);
        chk("to_after_d_error", d_error, 0);
`else
        for (int k = 0; k < 100; k++) tick();
        sample();
        chk("nto_m_access_held", m_access, 1);
        chk("nto_d_error", d_error, 0);
        tick();
        m_ack = 1;
        sample();
        chk("nto_late_d_ack", d_ack, 1);
        tick();
        m_ack = 0; d_access = 0;
`endif

        // ---- randomized traffic against transaction-level model ----
        tick();
        rst = 1;
        tick();
        rst = 0;
        owner = 0; last_g = 1; wait_cnt = 0; pend_i = 0; pend_d = 0;
        e_addr = '0; e_wr_val = '0; e_bytesel = '0; e_wr_en = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (!pend_i && $urandom_range(0, 2) == 0) begin
                pend_i = 1;
                ri_addr = $urandom & 32'hffff_fffc;
            end
            if (!pend_d && $urandom_range(0, 2) == 0) begin
                pend_d = 1;
                rd_addr = $urandom & 32'hffff_fffc;
                rd_wr_val = $urandom;
                rd_bytesel = 4'($urandom_range(0, 15));
                rd_wr_en = 1'($urandom_range(0, 1));
            end
            i_addr = ri_addr; d_addr = rd_addr; d_wr_val = rd_wr_val;
            d_bytesel = rd_bytesel; d_wr_en = rd_wr_en;
            // A granted master may let go early; the transaction must still finish.
            i_access = pend_i && !(owner == 1 && $urandom_range(0, 3) == 0);
            d_access = pend_d && !(owner == 2 && $urandom_range(0, 3) == 0);
            ack_now = 0; err_now = 0;
            if (owner != 0 && (wait_cnt >= 2 || $urandom_range(0, 2) == 0)) begin
                r = $urandom_range(0, 3);
                ack_now = (r != 1);
                err_now = (r == 1 || r == 2);
            end
            m_ack = ack_now; m_error = err_now; m_data = $urandom;
            sample();
            chk("rnd_m_access", m_access, (owner != 0) ? 1 : 0);
            if (owner != 0) begin
                chk("rnd_m_addr", m_addr, e_addr);
                chk("rnd_m_bytesel", m_bytesel, e_bytesel);
                chk("rnd_m_wr_en", m_wr_en, e_wr_en);
                chk("rnd_m_wr_val", m_wr_val, e_wr_val);
            end
            chk("rnd_i_ack", i_ack, (owner == 1 && ack_now && !err_now) ? 1 : 0);
            chk("rnd_i_error", i_error, (owner == 1 && err_now) ? 1 : 0);
            chk("rnd_d_ack", d_ack, (owner == 2 && ack_now && !err_now) ? 1 : 0);
            chk("rnd_d_error", d_error, (owner == 2 && err_now) ? 1 : 0);
            if (owner == 1 && ack_now && !err_now) chk("rnd_i_data", i_data, m_data);
            if (owner == 2 && ack_now && !err_now) chk("rnd_d_data", d_data, m_data);
            if (owner != 0) begin
                if (ack_now || err_now) begin
                    if (owner == 1) pend_i = 0; else pend_d = 0;
                    owner = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                if (pend_d && (!pend_i || last_g == 1)) begin
                    owner = 2; last_g = 2;
                    e_addr = rd_addr; e_bytesel = rd_bytesel;
                    e_wr_en = rd_wr_en; e_wr_val = rd_wr_val;
                end else if (pend_i) begin
                    owner = 1; last_g = 1;
                    e_addr = ri_addr; e_bytesel = 4'hf;
                    e_wr_en = 0; e_wr_val = '0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oldland_bus_arbiter.md
# oldland_bus_arbiter

Two-master arbiter that shares the single external memory bus between the instruction fetch port and the memory-stage data port. Requests are arbitrated round-robin, and the winner's address and write fields are latched. The arbiter drives one bus transaction at a time and routes the bus ack, error and read data back to the granted master only. It sits between the fetch stage, the memory stage and the memory/peripheral interconnect.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: cycles in a granted state with no m_ack/m_error before the arbiter aborts. Used only when timeout is compiled in.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- i_addr  in  32  fetch address, word aligned.
- i_access  in  1  fetch request; held until i_ack or i_error.
- i_data  out  32  fetch read data; valid with i_ack.
- i_ack  out  1  fetch complete, one-cycle pulse.
- i_error  out  1  fetch bus error, one-cycle pulse.
- d_addr  in  32  data address, word aligned.
- d_bytesel  in  4  data byte enables.
- d_wr_en  in  1  data write.
- d_wr_val  in  32  data write value, pre-rotated.
- d_access  in  1  data request; held until d_ack or d_error.
- d_data  out  32  data read value; valid with d_ack.
- d_ack  out  1  data complete, one-cycle pulse.
- d_error  out  1  data bus error, one-cycle pulse.
- m_addr  out  32  bus address, registered.
- m_bytesel  out  4  bus byte enables, registered.
- m_wr_en  out  1  bus write, registered.
- m_wr_val  out  32  bus write value, registered.
- m_access  out  1  bus transaction active, registered.
- m_data  in  32  bus read data.
- m_ack  in  1  bus transaction complete.
- m_error  in  1  bus transaction failed; terminates the transaction like m_ack.

## Operation
- States: IDLE, GRANT_I, GRANT_D.
- IDLE, no request: stay in IDLE.
- IDLE, one request: go to that master's GRANT state.
- IDLE, both requesting: grant the master not granted last. A `last` flag records the previous grant; its reset value is "instruction", so data wins the first tie.
- On entering a GRANT state, latch the request fields into the m_* registers and set m_access=1.
  - Fetch: m_bytesel=4'b1111, m_wr_en=0, m_wr_val=0.
  - Update `last`.
- GRANT_x, m_ack or m_error: assert x_ack or x_error combinationally that same cycle, drive x_data=m_data, and return to IDLE. m_access=0 from the next cycle.
- If m_ack and m_error are both set, the error wins: x_error=1, x_ack=0.
- The ungranted master's ack and error are always 0. Its data output is don't-care (driven by m_data).
- Deassertion of x_access while granted is ignored. The transaction runs to m_ack/m_error, and the resulting pulse is still issued.
- The m_* fields are stable for the whole grant.
- Reset: state=IDLE, `last`=instruction, and all m_* outputs and the ack/error outputs are 0. Reset in the middle of a transaction aborts it with no ack or error pulse.

## Timing
- Request first high in cycle N with the bus idle: state and m_access=1 in N+1.
- m_ack in cycle M (M≥N+1, zero-wait slave M=N+1): x_ack in M; IDLE in M+1, m_access=0 in M+1.
- Earliest next grant: m_access=1 in M+2. Minimum transaction spacing is 2 cycles per access.
- A request arriving in the ack cycle M is sampled in IDLE at M+1.
- No combinational path from x_access to m_*. Combinational paths run only from m_ack/m_error/m_data to the x_* outputs.

## Configuration
- OLDLAND_BUS_TIMEOUT_EN defined:
  - A counter clears on grant entry and increments every granted cycle with no m_ack/m_error.
  - When it reaches TIMEOUT_CYCLES: pulse x_error for one cycle, clear m_access, and return to IDLE.
  - A late m_ack/m_error arriving in IDLE is ignored.
- OLDLAND_BUS_TIMEOUT_EN undefined: no counter; a grant waits indefinitely.

## Structure
- Shared package oldland_bus_pkg:
  - state encoding (IDLE=2'd0, GRANT_I=2'd1, GRANT_D=2'd2);
  - master-id constants;
  - default timeout value.
- Sub-module oldland_bus_timeout: load/enable counter with an expiry flag, instantiated only under OLDLAND_BUS_TIMEOUT_EN.

## Test plan
- Single data store, addr 0x1000, wr_val 0xdeadbeef, bytesel 4'b1111; slave acks 2 cycles after m_access -> m_* fields match in N+1, d_ack for one cycle, i_ack stays 0.
- i_access and d_access both raised in the same cycle, held after each ack -> grant order D, I, D, I; no bus cycle is lost.
- Fetch at 0x2000, slave returns m_data=0x12345678 with m_ack -> i_data=0x12345678 with i_ack in the same cycle; m_wr_en=0 and m_bytesel=4'b1111 throughout.
- Data load with m_ack and m_error asserted together -> d_error=1, d_ack=0, state returns to IDLE.
- rst asserted mid-grant -> m_access=0 immediately, no ack or error pulse; the first tie after release is granted to data.
- With OLDLAND_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, the slave never acks -> d_error pulses after 4 granted cycles and m_access drops the next cycle. Without the macro, m_access is still high after 100 cycles.
